// File: rtl/tbus_sram_responder_pkg.sv
// Shared tbus responder types: op-type encodings, bus widths and FSM states.
package tbus_sram_responder_pkg;

  localparam int unsigned RESULT_W      = 64;
  localparam int unsigned SRC_W         = 64;
  localparam int unsigned MASK_W        = 64;
  localparam int unsigned TBUS_OPTYPE_W = 2;
  localparam int unsigned CNT_W         = 4;

  localparam logic [TBUS_OPTYPE_W-1:0] TBUS_READ  = 2'b00;
  localparam logic [TBUS_OPTYPE_W-1:0] TBUS_WRITE = 2'b01;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  // Any encoding other than TBUS_WRITE behaves as a read.
  function automatic logic is_write(input logic [TBUS_OPTYPE_W-1:0] op);
    return op == TBUS_WRITE;
  endfunction

endpackage

// File: rtl/tbus_sram_responder_mem.sv
// Word-addressed SRAM model: synchronous bit-masked write, asynchronous read.
module tbus_resp_mem #(
  parameter int unsigned DEPTH_LOG = 10
) (
  input  logic                 clock,
  input  logic                 wr_en_i,
  input  logic [DEPTH_LOG-1:0] wr_idx_i,
  input  logic [63:0]          wr_data_i,
  input  logic [63:0]          wr_mask_i,
  input  logic [DEPTH_LOG-1:0] rd_idx_i,
  output logic [63:0]          rd_data_o
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG;

  logic [63:0] mem_q [DEPTH];

  // Contents are deliberately left unreset.
  always_ff @(posedge clock) begin
    if (wr_en_i) begin
      mem_q[wr_idx_i] <= (mem_q[wr_idx_i] & ~wr_mask_i) | (wr_data_i & wr_mask_i);
    end
  end

  assign rd_data_o = mem_q[rd_idx_i];

endmodule

// File: rtl/tbus_sram_responder.sv
// tbus responder in front of an SRAM model: one request at a time, fixed latency.
// Optional build macro TBUS_RESP_FLUSH_EN lets memblock2dcache_flush squash requests.
module tbus_sram_responder
  import tbus_sram_responder_pkg::*;
#(
  parameter int unsigned DEPTH_LOG = 10,
  parameter int unsigned LATENCY   = 2
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     tbus_index_valid,
  output logic                     tbus_index_ready,
  input  logic [RESULT_W-1:0]      tbus_index,
  input  logic [SRC_W-1:0]         tbus_write_data,
  input  logic [MASK_W-1:0]        tbus_write_mask,
  input  logic [TBUS_OPTYPE_W-1:0] tbus_operation_type,
  output logic [RESULT_W-1:0]      tbus_read_data,
  output logic                     tbus_operation_done,
  input  logic                     memblock2dcache_flush
);

  state_e                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [DEPTH_LOG-1:0]     idx_q, idx_d;
  logic [TBUS_OPTYPE_W-1:0] op_q, op_d;
  logic [DEPTH_LOG-1:0]     req_idx;
  logic                     mem_we;
  logic [63:0]              mem_rdata;
  logic                     flush_c;
  logic                     unused_index_bits;

  // Byte offset and bits above the array size are dropped, so addresses alias.
  assign req_idx           = tbus_index[DEPTH_LOG+2:3];
  assign unused_index_bits = ^{tbus_index[2:0], tbus_index[RESULT_W-1:DEPTH_LOG+3]};

`ifdef TBUS_RESP_FLUSH_EN
  assign flush_c = memblock2dcache_flush;
`else
  logic unused_flush;
  assign flush_c      = 1'b0;
  assign unused_flush = memblock2dcache_flush;
`endif

  tbus_resp_mem #(
    .DEPTH_LOG (DEPTH_LOG)
  ) u_mem (
    .clock     (clock),
    .wr_en_i   (mem_we),
    .wr_idx_i  (req_idx),
    .wr_data_i (tbus_write_data),
    .wr_mask_i (tbus_write_mask),
    .rd_idx_i  (idx_q),
    .rd_data_o (mem_rdata)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      op_q    <= TBUS_READ;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      op_q    <= op_d;
    end
  end

  // Next-state and decoded outputs; the array write happens on the accept edge.
  always_comb begin
    state_d             = state_q;
    cnt_d               = cnt_q;
    idx_d               = idx_q;
    op_d                = op_q;
    mem_we              = 1'b0;
    tbus_index_ready    = 1'b0;
    tbus_operation_done = 1'b0;
    tbus_read_data      = '0;

    case (state_q)
      IDLE: begin
        tbus_index_ready = !flush_c;
        if (tbus_index_valid && !flush_c) begin
          idx_d  = req_idx;
          op_d   = tbus_operation_type;
          mem_we = is_write(tbus_operation_type);
          if (LATENCY == 1) begin
            state_d = RESP;
          end else begin
            state_d = BUSY;
            cnt_d   = CNT_W'(LATENCY - 1);
          end
        end
      end
      BUSY: begin
        if (flush_c) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(1)) begin
          state_d = RESP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
        if (!flush_c) begin
          tbus_operation_done = 1'b1;
          if (!is_write(op_q)) begin
            tbus_read_data = mem_rdata;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
